// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared constants and elaboration-time helpers for the pipelined
// Kogge-Stone adder/subtractor (ksa_pipe_adder) and its prefix levels.
//
// Contents:
//   OP_ADD / OP_SUB : encodings of the in_sub mode bit
//   clog2(n)        : ceil(log2(n)) for n >= 1
//   LEVELS(w)       : number of Kogge-Stone prefix levels for width w
//   NSTAGE(w, pe)   : number of prefix register groups, ceil(LEVELS/pe)
// ---------------------------------------------------------------------------
package ksa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int LEVELS(input int w);
    return clog2(w);
  endfunction

  function automatic int NSTAGE(input int w, input int pe);
    return (LEVELS(w) + pe - 1) / pe;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// ---------------------------------------------------------------------------
// ksa_prefix_level
// One combinational Kogge-Stone prefix level with span 2^LEVEL.
//
// Ports:
//   i_g   [DATA_WIDTH] : group generate from the previous level
//   i_p   [DATA_WIDTH] : group propagate from the previous level
//   i_cin              : carry-in, treated as the generate of bit -1
//   o_g   [DATA_WIDTH] : group generate after this level
//   o_p   [DATA_WIDTH] : group propagate after this level
//
// Per bit i (span s = 2^LEVEL):
//   i <  s      : pass-through; the position already holds its full carry
//   s <= i < 2s : gray cell; the lower operand is already complete, so
//                 only the generate is combined
//   i >= 2s     : black cell; generate and propagate both combined
// The carry-in enters at level 0 by folding it into bit 0's generate before
// any cell reads it, so bit 1's level-0 gray cell already sees the full
// carry out of bit 0. That keeps the network at exactly log2(W) levels while
// covering W+1 carry sources.
// ---------------------------------------------------------------------------
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL      = 0
) (
  input  logic [DATA_WIDTH-1:0] i_g,
  input  logic [DATA_WIDTH-1:0] i_p,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_g,
  output logic [DATA_WIDTH-1:0] o_p
);

  localparam int SPAN = 1 << LEVEL;

  logic [DATA_WIDTH-1:0] w_g_lo;

  generate
    if (LEVEL == 0) begin : g_fold
      assign w_g_lo = {i_g[DATA_WIDTH-1:1], i_g[0] | (i_p[0] & i_cin)};
    end else begin : g_nofold
      // Carry-in is already inside the generates past level 0.
      logic w_unused_cin;
      assign w_unused_cin = i_cin;
      assign w_g_lo       = i_g;
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      if (i < SPAN) begin : g_pass
        assign o_g[i] = w_g_lo[i];
        assign o_p[i] = i_p[i];
      end else if (i < 2 * SPAN) begin : g_gray
        assign o_g[i] = w_g_lo[i] | (i_p[i] & w_g_lo[i-SPAN]);
        // Position becomes complete here; its propagate is never consumed
        // again except by other complete positions, which ignore it.
        assign o_p[i] = i_p[i];
      end else begin : g_black
        assign o_g[i] = w_g_lo[i] | (i_p[i] & w_g_lo[i-SPAN]);
        assign o_p[i] = i_p[i] & i_p[i-SPAN];
      end
    end
  endgenerate

endmodule

// File: rtl/ksa_pipe_adder.sv
// ---------------------------------------------------------------------------
// ksa_pipe_adder
// Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready
// handshake, carry-in, status flags and a pass-through tag.
//
// Parameters:
//   DATA_WIDTH : operand width, power of two, 4..128
//   PIPE_EVERY : prefix levels per register stage, 1..log2(DATA_WIDTH)
//   TAG_WIDTH  : opaque tag width, >= 1
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand beat handshake (in_ready is combinational)
//   in_a, in_b           : operands
//   in_cin               : carry-in, ignored when in_sub = 1
//   in_sub               : 0 = a+b+cin, 1 = a-b (a + ~b + 1)
//   in_tag               : tag returned with the result
//   out_valid / out_ready: result handshake
//   out_sum              : result modulo 2^DATA_WIDTH
//   out_cout             : carry-out (1 = no borrow when subtracting)
//   out_ovf              : signed overflow
//   out_zero             : out_sum == 0
//   out_tag              : tag of this result
//
// Pipeline: stage 0 register, then one register after every PIPE_EVERY
// prefix levels. The last group feeds the sum/flag logic directly into the
// output register, so latency is 1 + ceil(LEVELS/PIPE_EVERY) cycles.
// All stages advance together whenever the output slot is free or being
// drained; bubbles are carried, not collapsed.
// ---------------------------------------------------------------------------
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  out_zero,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int NUM_LEVELS = LEVELS(DATA_WIDTH);
  localparam int NUM_STAGES = NSTAGE(DATA_WIDTH, PIPE_EVERY);

  // Stage registers: index j feeds prefix group j.
  logic [NUM_STAGES-1:0] r_v;
  logic [DATA_WIDTH-1:0] r_g   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] r_p   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] r_pb  [NUM_STAGES];
  logic                  r_c   [NUM_STAGES];
  logic [TAG_WIDTH-1:0]  r_tag [NUM_STAGES];

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_sum;
  logic                  r_out_cout;
  logic                  r_out_ovf;
  logic                  r_out_zero;
  logic [TAG_WIDTH-1:0]  r_out_tag;

  logic                  w_adv;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic [DATA_WIDTH-1:0] w_go [NUM_LEVELS];
  logic [DATA_WIDTH-1:0] w_po [NUM_LEVELS-1];
  logic [DATA_WIDTH-1:0] w_g_fin;
  logic [DATA_WIDTH-1:0] w_carry;
  logic [DATA_WIDTH-1:0] w_sum;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = (in_sub == OP_SUB) ? ~in_b : in_b;

  always_ff @(posedge clk) begin : p_ctrl
    if (rst) begin
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      for (int j = 1; j < NUM_STAGES; j++) begin
        r_v[j] <= r_v[j-1];
      end
      r_out_valid <= r_v[NUM_STAGES-1];
      // Only real results reach the output register, so a bubble never
      // disturbs the last delivered values.
      if (r_v[NUM_STAGES-1]) begin
        r_out_sum  <= w_sum;
        r_out_cout <= w_g_fin[DATA_WIDTH-1];
        r_out_ovf  <= w_g_fin[DATA_WIDTH-2] ^ w_g_fin[DATA_WIDTH-1];
        r_out_zero <= ~|w_sum;
        r_out_tag  <= r_tag[NUM_STAGES-1];
      end
    end
  end

  always_ff @(posedge clk) begin : p_stage0
    if (w_adv) begin
      r_g[0]   <= in_a & w_b_eff;
      r_p[0]   <= in_a ^ w_b_eff;
      r_pb[0]  <= in_a ^ w_b_eff;
      r_c[0]   <= in_sub | in_cin;
      r_tag[0] <= in_tag;
    end
  end

  generate
    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
      logic [DATA_WIDTH-1:0] w_gi;
      logic [DATA_WIDTH-1:0] w_pi;
      logic [DATA_WIDTH-1:0] w_po_l;

      if (l % PIPE_EVERY == 0) begin : g_head
        assign w_gi = r_g[l/PIPE_EVERY];
        assign w_pi = r_p[l/PIPE_EVERY];
      end else begin : g_body
        assign w_gi = w_go[l-1];
        assign w_pi = w_po[l-1];
      end

      ksa_prefix_level #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEVEL      (l)
      ) u_level (
        .i_g   (w_gi),
        .i_p   (w_pi),
        .i_cin (r_c[l/PIPE_EVERY]),
        .o_g   (w_go[l]),
        .o_p   (w_po_l)
      );

      if (l < NUM_LEVELS - 1) begin : g_pout
        assign w_po[l] = w_po_l;
      end else begin : g_plast
        // After the final level every generate is a full carry; the
        // propagates have no further consumer.
        logic w_unused_p;
        assign w_unused_p = ^w_po_l;
      end
    end

    for (genvar j = 1; j < NUM_STAGES; j++) begin : g_stage
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_g[j]   <= w_go[j*PIPE_EVERY-1];
          r_p[j]   <= w_po[j*PIPE_EVERY-1];
          r_pb[j]  <= r_pb[j-1];
          r_c[j]   <= r_c[j-1];
          r_tag[j] <= r_tag[j-1];
        end
      end
    end
  endgenerate

  // Carry into bit i is the full generate of bit i-1; bit 0 takes the
  // effective carry-in.
  assign w_g_fin = w_go[NUM_LEVELS-1];
  assign w_carry = {w_g_fin[DATA_WIDTH-2:0], r_c[NUM_STAGES-1]};
  assign w_sum   = r_pb[NUM_STAGES-1] ^ w_carry;

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;

endmodule
